pitch_shift_sequencer: RTL
==========================

# pitch_shift_sequencer

Frame-level controller that sits directly in front of and behind `PitchShift`. It accepts a 2048-bin spectrum stream from the FFT stage over valid/ready and writes it into `PitchShift` through `data_in`/`input_index`/`en`. It applies any pending semitone setting only at frame boundaries, then reads the shifted frame back through `output_index`/`data_out` and emits it as a valid/ready stream toward the IFFT stage.

## Interface
- `N_BINS`, 2048, bins per frame.
- `IDX_W`, 11, bin index width; `2**IDX_W == N_BINS`.
- `DATA_W`, 32, bin word width (16.16 fixed point; opaque to this block).
- `READ_LATENCY`, 1, cycles from `ps_output_index` being sampled to `ps_data_out` being valid (1..3).
- Ports (name, direction, width, meaning):
  - `clk` in 1: single clock; all logic on its rising edge.
  - `rst_n` in 1: reset, synchronous, active-low.
  - `s_data` in DATA_W: input bin.
  - `s_valid` in 1 / `s_ready` out 1: input handshake.
  - `s_last` in 1: marks bin N_BINS-1.
  - `m_data` out DATA_W: output bin.
  - `m_valid` out 1 / `m_ready` in 1: output handshake.
  - `m_last` out 1: high with bin N_BINS-1.
  - `cfg_semitones` in 5: signed shift request.
  - `cfg_wr` in 1: one-cycle strobe that latches `cfg_semitones` as pending.
  - `ps_data_in` out DATA_W, `ps_input_index` out IDX_W, `ps_en` out 1: PitchShift write port.
  - `ps_output_index` out IDX_W, `ps_data_out` in DATA_W: PitchShift read port.
  - `ps_shift_semitones` out 5, `ps_shift_wr_en` out 1: PitchShift shift load.
  - `busy` out 1: high whenever the FSM is not IDLE.
  - `frame_err` out 1: one-cycle pulse on an `s_last` mismatch.

## Operation
- FSM states: IDLE, CFG, LOAD, DRAIN.
- IDLE:
  - Pending flag set → CFG.
  - Otherwise `s_valid` → LOAD.
- CFG (exactly 1 cycle):
  - `ps_shift_semitones` = pending value; `ps_shift_wr_en` = 1.
  - Pending flag clears; → LOAD.
- LOAD:
  - `s_ready` = 1; `ps_en` = `s_valid`; `ps_data_in` = `s_data`; `ps_input_index` = load counter.
  - Counter increments on each accepted beat.
  - On the beat with counter = N_BINS-1 → DRAIN, counter → 0.
- DRAIN:
  - Issue read index `rd_idx` (0..N_BINS-1) whenever credits allow.
  - Capture `ps_data_out` READ_LATENCY cycles later into an output FIFO of depth READ_LATENCY+2.
  - Issue is allowed only if FIFO occupancy + in-flight reads < depth, so no data is ever dropped under `m_ready` backpressure.
  - After the pop of bin N_BINS-1 → IDLE.
- Shift configuration:
  - `cfg_wr` in any state overwrites the pending value and sets the pending flag; the last write before a frame boundary wins.
  - `cfg_wr` in the same cycle as CFG: CFG applies the old pending value, and the new value stays pending for the next frame.
- After reset the pending flag = 1 with value 0, so the first frame always writes a known shift.
- `m_last` = 1 exactly when bin N_BINS-1 is at the FIFO head.
- `ps_shift_semitones` holds its last written value outside CFG.

## Timing
- Reset values: `s_ready`, `m_valid`, `m_last`, `ps_en`, `ps_shift_wr_en`, `busy`, `frame_err` = 0; `m_data`, `ps_input_index`, `ps_output_index`, `ps_shift_semitones` = 0; FSM = IDLE; FIFO empty; counters = 0.
- Reset mid-frame: everything returns to the reset values at the next edge; the partial frame is discarded and in-flight reads are dropped.
- LOAD path is combinational from `s_*` to `ps_en`/`ps_data_in`; `ps_input_index` is registered.
- Sustained throughput is 1 bin/cycle in each phase with `m_ready` held high.
- Minimum frame period is N_BINS + N_BINS + READ_LATENCY + 2 cycles, plus 1 if a CFG cycle is needed.
- First `m_valid` asserts READ_LATENCY+1 cycles after entering DRAIN.
- `m_data`/`m_last` are stable while `m_valid && !m_ready`.
- `s_ready` = 0 in IDLE, CFG and DRAIN; the upstream stalls during drain.

## Configuration
- `PS_SEQ_LAST_CHECK_EN` defined:
  - `frame_err` pulses one cycle after an accepted beat where `s_last` ≠ (counter == N_BINS-1).
  - Framing is still governed solely by the counter.
- Not defined:
  - `s_last` is ignored.
  - `frame_err` is tied to 0.

## Test plan
- Reset, then stream bins `i<<16` for i=0..2047 with `m_ready`=1 → one CFG cycle with `ps_shift_semitones`=0, then 2048 `ps_en` beats with `ps_input_index`=i, then `ps_output_index` 0..2047 and 2048 output beats, with `m_last` only on the last beat.
- `cfg_wr` with `cfg_semitones`=6 mid-LOAD → no `ps_shift_wr_en` in the current frame; exactly one `ps_shift_wr_en` with value 6 before the next frame's first `ps_en`.
- `cfg_wr` with 6 then -6 (5'b11010) before a frame → a single CFG cycle writing 5'b11010.
- `m_ready` toggling 1/0 every cycle, READ_LATENCY=1 and 3 → all 2048 outputs in order with no loss or duplication; `m_data` held while stalled.
- `rst_n`=0 at load beat 1000 → all outputs at reset values next edge; the next full frame processes normally, starting at index 0.
- Macro defined, `s_last` asserted at beat 100 → `frame_err` pulses once and the frame still completes at 2048 beats; macro undefined → `frame_err` stays 0.

Source files
------------

// File: rtl/pitch_shift_sequencer.sv
// Frame sequencer around PitchShift: loads a 2048-bin frame, applies pending shift at frame
// boundaries, drains through a credit-limited FIFO. Optional macro: PS_SEQ_LAST_CHECK_EN.
module pitch_shift_sequencer #(
  parameter int N_BINS       = 2048,
  parameter int IDX_W        = 11,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  input  logic [4:0]        cfg_semitones,
  input  logic              cfg_wr,
  output logic [DATA_W-1:0] ps_data_in,
  output logic [IDX_W-1:0]  ps_input_index,
  output logic              ps_en,
  output logic [IDX_W-1:0]  ps_output_index,
  input  logic [DATA_W-1:0] ps_data_out,
  output logic [4:0]        ps_shift_semitones,
  output logic              ps_shift_wr_en,
  output logic              busy,
  output logic              frame_err
);

  localparam int DEPTH = READ_LATENCY + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);

  typedef enum logic [1:0] {IDLE, CFG, LOAD, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic                    pend_q, pend_d;
  logic [4:0]              pend_val_q, pend_val_d;
  logic [4:0]              shift_q, shift_d;
  logic [IDX_W-1:0]        ld_cnt_q, ld_cnt_d;
  logic [IDX_W:0]          rd_cnt_q, rd_cnt_d;
  logic [IDX_W-1:0]        out_cnt_q, out_cnt_d;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        occ_q, occ_d;
  logic [DATA_W-1:0]       fifo_mem_q [DEPTH];
  logic [CNT_W-1:0]        in_flight;
  logic [CNT_W:0]          used;
  logic                    accept, issue, capture, pop;

  // A read may only be issued if its data is guaranteed a FIFO slot on return.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) in_flight = in_flight + CNT_W'(pipe_q[i]);
    used    = {1'b0, occ_q} + {1'b0, in_flight};
    accept  = (state_q == LOAD) && s_valid;
    issue   = (state_q == DRAIN) && (rd_cnt_q < (IDX_W+1)'(N_BINS)) &&
              (used < (CNT_W+1)'(DEPTH));
    capture = pipe_q[READ_LATENCY-1];
    pop     = (occ_q != '0) && m_ready;
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    shift_d    = shift_q;
    ld_cnt_d   = ld_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    out_cnt_d  = out_cnt_q;
    case (state_q)
      IDLE: begin
        if (pend_q) state_d = CFG;
        else if (s_valid) state_d = LOAD;
      end
      CFG: begin
        shift_d = pend_val_q;
        pend_d  = 1'b0;
        state_d = LOAD;
      end
      LOAD: begin
        if (accept) begin
          if (ld_cnt_q == LAST_IDX) begin
            ld_cnt_d = '0;
            state_d  = DRAIN;
          end else begin
            ld_cnt_d = ld_cnt_q + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (issue) rd_cnt_d = rd_cnt_q + (IDX_W+1)'(1);
        if (pop) out_cnt_d = out_cnt_q + IDX_W'(1);
        if (pop && (out_cnt_q == LAST_IDX)) begin
          out_cnt_d = '0;
          rd_cnt_d  = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A write landing in the CFG cycle survives the clear and stays pending.
    if (cfg_wr) begin
      pend_d     = 1'b1;
      pend_val_d = cfg_semitones;
    end
  end

  always_comb begin
    pipe_d[0] = issue;
    for (int i = 1; i < READ_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (capture) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
    occ_d = occ_q + CNT_W'(capture) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= 1'b1;
      pend_val_q <= '0;
      shift_q    <= '0;
      ld_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      pipe_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      shift_q    <= shift_d;
      ld_cnt_q   <= ld_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      pipe_q     <= pipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) fifo_mem_q[wr_ptr_q] <= ps_data_out;
  end

  assign s_ready            = (state_q == LOAD);
  assign ps_en              = accept;
  assign ps_data_in         = s_data;
  assign ps_input_index     = ld_cnt_q;
  assign ps_output_index    = rd_cnt_q[IDX_W-1:0];
  assign ps_shift_wr_en     = (state_q == CFG);
  assign ps_shift_semitones = (state_q == CFG) ? pend_val_q : shift_q;
  assign m_valid            = (occ_q != '0);
  assign m_data             = m_valid ? fifo_mem_q[rd_ptr_q] : '0;
  assign m_last             = m_valid && (out_cnt_q == LAST_IDX);
  assign busy               = (state_q != IDLE);

`ifdef PS_SEQ_LAST_CHECK_EN
  logic frame_err_q, frame_err_d;

  // Framing follows the counter; s_last only produces a diagnostic pulse.
  always_comb frame_err_d = accept && (s_last != (ld_cnt_q == LAST_IDX));

  always_ff @(posedge clk) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end

  assign frame_err = frame_err_q;
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign frame_err     = 1'b0;
`endif

endmodule
